// File: rtl/seed_req_arbiter_pkg.sv
// Shared constants for the SEED128 request arbiter: FSM encoding, block width,
// and the nominal core latency.
package seed_req_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'h0;
    localparam logic [1:0] ST_ISSUE = 2'h1;
    localparam logic [1:0] ST_WAIT  = 2'h2;
    localparam logic [1:0] ST_RESP  = 2'h3;

    localparam int BLK_W    = 128;
    localparam int CORE_LAT = 18;

endpackage

// File: rtl/seed_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after the pointer,
// wrapping modulo NREQ (NREQ need not be a power of two).
module seed_rr_pick
    import seed_req_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_Req,
    input  logic [IW-1:0]   i_Ptr,
    output logic [IW-1:0]   o_Idx,
    output logic            o_Vld
);

    logic [IW-1:0] w_Cand;

    always_comb begin
        o_Idx  = '0;
        o_Vld  = 1'b0;
        w_Cand = '0;
        // Scan farthest-first so the nearest candidate to the pointer is the last writer.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_Cand = IW'((int'(i_Ptr) + k) % NREQ);
            if (i_Req[w_Cand]) begin
                o_Idx = w_Cand;
                o_Vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seed_req_arbiter.sv
// Shares one SEED128 core among NREQ requesters: round-robin pick, operand latch,
// start pulse, done/timeout wait, and a one-cycle response to the owner.
module seed_req_arbiter
    import seed_req_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 32,
    parameter int CW      = 6
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NREQ-1:0]       i_Req,
    input  logic [NREQ*BLK_W-1:0] i_Text,
    input  logic [NREQ*BLK_W-1:0] i_Key,
    input  logic [NREQ-1:0]       i_Dec,
    output logic [NREQ-1:0]       o_Gnt,
    output logic [NREQ-1:0]       o_Done,
    output logic [BLK_W-1:0]      o_Text,
    output logic                  o_Err,
    output logic                  o_Busy,
    output logic                  o_Core_fStart,
    output logic [BLK_W-1:0]      o_Core_Text,
    output logic [BLK_W-1:0]      o_Core_Key,
    output logic                  o_Core_Dec,
    input  logic [BLK_W-1:0]      i_Core_Text,
    input  logic                  i_Core_fDone
);

    localparam int              IW  = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [1:0]       r_State;
    logic [IW-1:0]    r_Ptr;
    logic [IW-1:0]    r_Idx;
    logic [CW-1:0]    r_Timer;
    logic [NREQ-1:0]  r_Gnt;
    logic [NREQ-1:0]  r_Done;
    logic [BLK_W-1:0] r_Text;
    logic             r_Err;
    logic             r_Busy;
    logic             r_fStart;
    logic [BLK_W-1:0] r_CoreText;
    logic [BLK_W-1:0] r_CoreKey;
    logic             r_CoreDec;

    logic [IW-1:0]    w_Win;
    logic             w_WinVld;
    logic [BLK_W-1:0] w_SelText;
    logic [BLK_W-1:0] w_SelKey;
    logic             w_SelDec;
    logic [CW-1:0]    w_TimerNxt;
    logic             w_Timeout;

    seed_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_Req (i_Req),
        .i_Ptr (r_Ptr),
        .o_Idx (w_Win),
        .o_Vld (w_WinVld)
    );

    always_comb begin
        w_SelText = '0;
        w_SelKey  = '0;
        w_SelDec  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_Win == IW'(k)) begin
                w_SelText = i_Text[k*BLK_W +: BLK_W];
                w_SelKey  = i_Key[k*BLK_W +: BLK_W];
                w_SelDec  = i_Dec[k];
            end
        end
    end

    assign w_TimerNxt = r_Timer + CW'(1);
    assign w_Timeout  = (w_TimerNxt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= ST_IDLE;
            r_Ptr      <= '0;
            r_Idx      <= '0;
            r_Timer    <= '0;
            r_Gnt      <= '0;
            r_Done     <= '0;
            r_Text     <= '0;
            r_Err      <= 1'b0;
            r_Busy     <= 1'b0;
            r_fStart   <= 1'b0;
            r_CoreText <= '0;
            r_CoreKey  <= '0;
            r_CoreDec  <= 1'b0;
        end else begin
            r_Gnt    <= '0;
            r_fStart <= 1'b0;
            r_Done   <= '0;
            case (r_State)
                ST_IDLE: begin
                    if (w_WinVld) begin
                        r_Idx      <= w_Win;
                        r_CoreText <= w_SelText;
                        r_CoreKey  <= w_SelKey;
                        r_CoreDec  <= w_SelDec;
                        r_Gnt      <= ONE << w_Win;
                        r_fStart   <= 1'b1;
                        r_Busy     <= 1'b1;
                        r_State    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_Timer <= '0;
                    r_State <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_Timer <= w_TimerNxt;
                    // Done is checked first so it wins a tie with the watchdog.
                    if (i_Core_fDone) begin
                        r_Text  <= i_Core_Text;
                        r_Err   <= 1'b0;
                        r_Done  <= ONE << r_Idx;
                        r_State <= ST_RESP;
                    end else if (w_Timeout) begin
                        r_Text  <= '0;
                        r_Err   <= 1'b1;
                        r_Done  <= ONE << r_Idx;
                        r_State <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_Text  <= '0;
                    r_Err   <= 1'b0;
                    r_Ptr   <= (r_Idx == IW'(NREQ - 1)) ? '0 : r_Idx + IW'(1);
                    r_Busy  <= 1'b0;
                    r_State <= ST_IDLE;
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    assign o_Gnt         = r_Gnt;
    assign o_Done        = r_Done;
    assign o_Text        = r_Text;
    assign o_Err         = r_Err;
    assign o_Busy        = r_Busy;
    assign o_Core_fStart = r_fStart;
    assign o_Core_Text   = r_CoreText;
    assign o_Core_Key    = r_CoreKey;
    assign o_Core_Dec    = r_CoreDec;

endmodule

// File: tb/tb_seed_req_arbiter.sv
// Scoreboard bench for seed_req_arbiter: a queue-based service-order model predicts
// grants and responses; a behavioural core answers each start after a chosen latency.
module tb_seed_req_arbiter;
    import seed_req_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TO = 32;
    localparam int CW = 6;
    localparam logic [127:0] KAT_PT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT_CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;

    logic             clk = 1'b0;
    logic             i_Rst;
    logic [N-1:0]     i_Req;
    logic [N*128-1:0] i_Text, i_Key;
    logic [N-1:0]     i_Dec;
    logic [N-1:0]     o_Gnt, o_Done;
    logic [127:0]     o_Text, o_Core_Text, o_Core_Key, i_Core_Text;
    logic             o_Err, o_Busy, o_Core_fStart, o_Core_Dec, i_Core_fDone;
    logic             core_done, spur_done;

    assign i_Core_fDone = core_done | spur_done;
    always #5 clk = ~clk;

    seed_req_arbiter #(.NREQ(N), .TIMEOUT(TO), .CW(CW)) dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Text(i_Text), .i_Key(i_Key),
        .i_Dec(i_Dec), .o_Gnt(o_Gnt), .o_Done(o_Done), .o_Text(o_Text), .o_Err(o_Err),
        .o_Busy(o_Busy), .o_Core_fStart(o_Core_fStart), .o_Core_Text(o_Core_Text),
        .o_Core_Key(o_Core_Key), .o_Core_Dec(o_Core_Dec), .i_Core_Text(i_Core_Text),
        .i_Core_fDone(i_Core_fDone)
    );

    typedef struct {
        int           idx;
        logic [127:0] pt;
        logic [127:0] key;
        logic         dec;
        int           lat;
        logic [127:0] res;
        logic         err;
    } exp_t;

    exp_t gnt_q[$];
    exp_t done_q[$];
    int   lat_q[$];

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           gnt_cyc = 0;
    int           mp = 0;
    logic [127:0] rq_pt [N];
    logic [127:0] rq_key[N];
    logic         rq_dec[N];
    int           rq_lat[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key,
                                             input logic dec);
        if (!dec && key == '0 && pt == KAT_PT) return KAT_CT;
        return {pt[63:0], pt[127:64]} ^ key ^ {128{dec}} ^ 128'h1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Service order for a set of simultaneous held requests: repeatedly take the first
    // pending requester at or after the model pointer, then move the pointer past it.
    task automatic plan(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        exp_t         e;
        int           w;
        pend = mask;
        while (pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(mp + k) % N]) w = (mp + k) % N;
            e.idx = w;
            e.pt  = rq_pt[w];
            e.key = rq_key[w];
            e.dec = rq_dec[w];
            e.lat = rq_lat[w];
            e.err = (rq_lat[w] == 0);
            e.res = e.err ? '0 : core_fn(rq_pt[w], rq_key[w], rq_dec[w]);
            gnt_q.push_back(e);
            done_q.push_back(e);
            lat_q.push_back(rq_lat[w]);
            mp = (w + 1) % N;
            pend[w] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            i_Text[k*128 +: 128] = rq_pt[k];
            i_Key[k*128 +: 128]  = rq_key[k];
            i_Dec[k]             = rq_dec[k];
        end
        i_Req = mask;
    endtask

    task automatic set_rq(input int k, input logic [127:0] pt, input logic [127:0] key,
                          input logic dec, input int lat);
        rq_pt[k] = pt; rq_key[k] = key; rq_dec[k] = dec; rq_lat[k] = lat;
    endtask

    // Requesters drop their line in the grant cycle; optional extra pulse on wd_idx.
    task automatic run(input int budget, input int wd_idx, input int wd_on, input int wd_off);
        int n;
        n = 0;
        while (done_q.size() != 0 && n < budget) begin
            @(negedge clk);
            i_Req = i_Req & ~o_Gnt;
            if (wd_idx >= 0 && n == wd_on)  i_Req[wd_idx] = 1'b1;
            if (wd_idx >= 0 && n == wd_off) i_Req[wd_idx] = 1'b0;
            n++;
        end
        if (done_q.size() != 0) begin
            chk("run_budget_expired", 128'(done_q.size()), '0);
            gnt_q.delete(); done_q.delete(); lat_q.delete();
        end
    endtask

    task automatic wait_gnt(input int budget);
        int n;
        n = 0;
        while (o_Gnt == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_Gnt == '0) chk("wait_gnt_expired", 128'(n), '0);
        i_Req = i_Req & ~o_Gnt;
    endtask

    task automatic do_reset(input int ncyc);
        i_Rst = 1'b1;
        i_Req = '0;
        repeat (ncyc) @(negedge clk);
        chk("rst_ctl", 128'({o_Gnt, o_Done, o_Err, o_Busy, o_Core_fStart, o_Core_Dec}), '0);
        chk("rst_text", o_Text, '0);
        chk("rst_core_text", o_Core_Text, '0);
        chk("rst_core_key", o_Core_Key, '0);
        gnt_q.delete(); done_q.delete(); lat_q.delete();
        mp    = 0;
        i_Rst = 1'b0;
    endtask

    // Behavioural core: answers each start after the planned latency (0 = never).
    initial begin
        int           l;
        logic [127:0] r;
        core_done   = 1'b0;
        i_Core_Text = rnd128();
        forever begin
            @(negedge clk);
            if (o_Core_fStart) begin
                l = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                r = core_fn(o_Core_Text, o_Core_Key, o_Core_Dec);
                if (l > 0) begin
                    repeat (l) @(negedge clk);
                    core_done   = 1'b1;
                    i_Core_Text = r;
                    @(negedge clk);
                    core_done   = 1'b0;
                    i_Core_Text = ~r;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion.
    always @(negedge clk) begin
        exp_t e;
        if (!i_Rst) begin
            if (o_Gnt != '0) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", 128'(o_Gnt), '0);
                else begin
                    e = gnt_q.pop_front();
                    chk("gnt_owner", 128'(o_Gnt), 128'(1) << e.idx);
                    chk("gnt_start_busy", 128'({o_Core_fStart, o_Busy}), 128'(2'b11));
                    chk("core_text", o_Core_Text, e.pt);
                    chk("core_key", o_Core_Key, e.key);
                    chk("core_dec_issue", 128'(o_Core_Dec), 128'(e.dec));
                    gnt_cyc = cyc;
                end
            end
            if (o_Done != '0) begin
                if (done_q.size() == 0) chk("done_unexpected", 128'(o_Done), '0);
                else begin
                    e = done_q.pop_front();
                    chk("done_owner", 128'(o_Done), 128'(1) << e.idx);
                    chk("done_text", o_Text, e.res);
                    chk("done_err", 128'(o_Err), 128'(e.err));
                    chk("core_dec_resp", 128'(o_Core_Dec), 128'(e.dec));
                    chk("done_latency", 128'(cyc - gnt_cyc),
                        128'((e.lat == 0) ? TO : e.lat + 1));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] m;
        i_Req = '0; i_Text = '0; i_Key = '0; i_Dec = '0; spur_done = 1'b0;
        for (int k = 0; k < N; k++) set_rq(k, rnd128(), rnd128(), 1'b0, CORE_LAT);
        do_reset(3);
        @(negedge clk);

        // Known-answer encrypt on requester 0; grant one cycle after sampling.
        set_rq(0, KAT_PT, '0, 1'b0, CORE_LAT);
        plan(3'b001);
        @(negedge clk);
        chk("kat_gnt_t1", 128'(o_Gnt), 128'(3'b001));
        i_Req = i_Req & ~o_Gnt;
        run(100, -1, 0, 0);

        // Simultaneous requests from reset: 0,1,0,1.
        do_reset(1);
        set_rq(0, rnd128(), rnd128(), 1'b0, CORE_LAT);
        set_rq(1, rnd128(), rnd128(), 1'b0, 20);
        plan(3'b011);
        run(200, -1, 0, 0);
        plan(3'b011);
        run(200, -1, 0, 0);

        // Decrypt on requester 1.
        set_rq(1, rnd128(), rnd128(), 1'b1, 21);
        plan(3'b010);
        run(100, -1, 0, 0);

        // Watchdog, then a normal op, then done coinciding with the timeout edge.
        set_rq(2, rnd128(), rnd128(), 1'b0, 0);
        plan(3'b100);
        run(100, -1, 0, 0);
        set_rq(0, rnd128(), rnd128(), 1'b1, CORE_LAT);
        plan(3'b001);
        run(100, -1, 0, 0);
        set_rq(1, rnd128(), rnd128(), 1'b0, TO - 1);
        plan(3'b010);
        run(100, -1, 0, 0);

        // Reset five cycles into an op whose late done arrives afterwards.
        set_rq(0, rnd128(), rnd128(), 1'b0, CORE_LAT);
        plan(3'b001);
        run(100, -1, 0, 0);
        set_rq(1, rnd128(), rnd128(), 1'b0, 22);
        plan(3'b010);
        wait_gnt(10);
        repeat (5) @(negedge clk);
        do_reset(1);
        repeat (30) @(negedge clk);
        chk("post_rst_idle", 128'({o_Busy, o_Done}), '0);
        set_rq(0, rnd128(), rnd128(), 1'b0, CORE_LAT);
        set_rq(1, rnd128(), rnd128(), 1'b0, CORE_LAT);
        plan(3'b011);
        run(200, -1, 0, 0);

        // Spurious done in IDLE, then a withdrawn pulse on requester 2 during WAIT.
        repeat (2) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_no_effect", 128'({o_Busy, o_Done, o_Gnt}), '0);
        @(negedge clk);
        chk("spur_no_effect2", 128'({o_Busy, o_Done, o_Gnt}), '0);
        set_rq(0, rnd128(), rnd128(), 1'b0, CORE_LAT);
        plan(3'b001);
        run(100, 2, 5, 8);
        repeat (4) @(negedge clk);

        // Randomized batches of held requests.
        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < N; k++)
                set_rq(k, rnd128(), rnd128(), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(18, 31)));
            m = N'($urandom_range(1, 7));
            plan(m);
            run(300, -1, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
